gpu_fbuf_write_arbiter: RTL and testbench
=========================================

GPU_FBUF_WRITE_ARBITER -- requirements
Module: gpu_fbuf_write_arbiter

Interface
REQ-001 SHALL have parameters: NUM_REQ, default 3, number of write requesters (0=single-pixel, 1=rect engine, 2=blit/spare).
REQ-002 SHALL have parameters: FBUF_ADDR_WIDTH, default 19, framebuffer word address width; FBUF_DATA_WIDTH, default 8, pixel width.
REQ-003 SHALL have parameters: FRAME_PIXELS, default 307200, number of valid addresses; MAX_BURST, default 16; IDLE_TIMEOUT, default 8.
REQ-004 SHALL have ports, clock and reset first:
 clk  in  1  clock
 rst_n  in  1  reset, synchronous, active-low
 req_valid  in  NUM_REQ  per-requester beat valid
 req_last  in  NUM_REQ  final beat of requester's burst
 req_addr  in  NUM_REQ*FBUF_ADDR_WIDTH  flattened addresses, requester i at slice i
 req_data  in  NUM_REQ*FBUF_DATA_WIDTH  flattened pixel data
 req_ready  out  NUM_REQ  beat accepted when valid&&ready
 fbuf_rst_busy  in  1  framebuffer clear in progress
 fbuf_en_wr, fbuf_wrea  out  1 each  BRAM enable/write-enable
 fbuf_addr  out  FBUF_ADDR_WIDTH  BRAM address
 fbuf_data  out  FBUF_DATA_WIDTH  BRAM data
 grant_valid  out  1  a requester holds the lock
 grant_id  out  2  locked requester index
 err_count  out  16  dropped out-of-range beats, saturating

Function
REQ-005 SHALL implement states IDLE, LOCKED, BLOCKED.
REQ-006 IDLE: if any req_valid, select first valid index searching upward from rr_ptr with wrap; register grant_id and enter LOCKED next cycle; req_ready all 0 in IDLE.
REQ-007 LOCKED: req_ready[grant_id] = !fbuf_rst_busy; all other req_ready 0.
REQ-008 Accepted beat SHALL appear on fbuf_* exactly 1 cycle later with fbuf_en_wr=fbuf_wrea=1; otherwise fbuf_en_wr=fbuf_wrea=0, addr/data 0.
REQ-009 Beat with addr >= FRAME_PIXELS SHALL be accepted (ready honoured) but not written; err_count increments, saturating at 16'hFFFF.
REQ-010 Beat counter SHALL count accepted beats per lock; lock releases after beat with req_last=1 or when count reaches MAX_BURST.
REQ-011 Idle counter SHALL count consecutive LOCKED cycles with req_valid[grant_id]=0; lock releases when it reaches IDLE_TIMEOUT.
REQ-012 On release, rr_ptr <= (grant_id+1) mod NUM_REQ; state -> IDLE; grant_valid drops same edge; one IDLE cycle always separates locks.
REQ-013 fbuf_rst_busy=1 in IDLE or LOCKED SHALL move to BLOCKED (lock retained if held); BLOCKED: all req_ready 0, no writes, counters frozen; returns to prior state when fbuf_rst_busy=0.
REQ-014 Simultaneous last beat and MAX_BURST reach SHALL count as one release; rr_ptr advances once.
REQ-015 Requester deasserting valid without last SHALL not corrupt data; only timeout releases.

Reset
REQ-016 rst_n=0 SHALL force state IDLE, rr_ptr 0, all counters 0, req_ready 0, fbuf_* 0, grant_valid 0, grant_id 0, err_count 0.
REQ-017 Reset mid-burst SHALL abandon the burst; pending registered beat SHALL not be written.

Structure
REQ-018 Shared package gpu_pkg SHALL hold arbiter state enum, FBUF widths, FRAME_WIDTH/HEIGHT and FRAME_PIXELS.
REQ-019 Round-robin priority search SHALL be sub-module gpu_rr_select (valid vector + pointer -> index + found).

Verification
REQ-020 Requester 1 sends 4 beats addr 0..3 data 0xA0..0xA3, last on 4th -> 4 writes, each 1 cycle after acceptance, then IDLE, rr_ptr=2.
REQ-021 All three valid continuously, last every beat -> grants order 0,1,2,0 with one IDLE cycle between.
REQ-022 Requester 0 streams 20 beats without last -> release after 16, requester 1 (valid) granted next.
REQ-023 fbuf_rst_busy high 5 cycles mid-burst -> ready 0, no writes, burst resumes with same grant_id.
REQ-024 Beat addr 307200 -> no fbuf_en_wr, err_count=1; granted requester silent 8 cycles -> lock released.

Source files
------------

// File: rtl/gpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gpu_pkg
// Description : Shared GPU framebuffer definitions: frame geometry, BRAM
//               word widths and the write-arbiter state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package gpu_pkg;

    // Frame geometry; one framebuffer word per pixel.
    localparam int FRAME_WIDTH  = 640;
    localparam int FRAME_HEIGHT = 480;
    localparam int FRAME_PIXELS = FRAME_WIDTH * FRAME_HEIGHT;

    // Framebuffer BRAM port widths.
    localparam int GPU_FBUF_ADDR_WIDTH = 19;
    localparam int GPU_FBUF_DATA_WIDTH = 8;

    // Width of the grant index exported by the arbiter (up to 4 requesters).
    localparam int GRANT_ID_WIDTH = 2;

    // Write-arbiter states.
    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_LOCKED  = 2'd1,
        ARB_BLOCKED = 2'd2
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/gpu_rr_select.sv
`default_nettype none
// ============================================================================
// Module      : gpu_rr_select
// Description : Round-robin priority search. Returns the first asserted bit
//               of 'valid' found searching upward from 'ptr' with wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module gpu_rr_select #(
    parameter int NUM_REQ   = 3,
    parameter int IDX_WIDTH = 2
) (
    input  logic [NUM_REQ-1:0]   valid,
    input  logic [IDX_WIDTH-1:0] ptr,
    output logic [IDX_WIDTH-1:0] idx,
    output logic                 found
);

    int w_cand;

    // Walk offsets from the far end down so the smallest offset from ptr is
    // the last one written and therefore wins.
    always_comb begin
        idx    = '0;
        found  = 1'b0;
        w_cand = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_cand = int'(ptr) + k;
            if (w_cand >= NUM_REQ) begin
                w_cand = w_cand - NUM_REQ;
            end
            if (valid[w_cand]) begin
                idx   = IDX_WIDTH'(w_cand);
                found = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/gpu_fbuf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : gpu_fbuf_write_arbiter
// Description : Round-robin burst-locking arbiter for framebuffer writes.
//               A granted requester keeps the BRAM write port until it sends
//               its last beat, hits MAX_BURST, or goes silent for
//               IDLE_TIMEOUT cycles. Accepted beats are written one cycle
//               later; out-of-frame beats are dropped and counted.
// Revision    : 1.0 - initial release
// ============================================================================
module gpu_fbuf_write_arbiter
    import gpu_pkg::*;
#(
    parameter int NUM_REQ         = 3,
    parameter int FBUF_ADDR_WIDTH = gpu_pkg::GPU_FBUF_ADDR_WIDTH,
    parameter int FBUF_DATA_WIDTH = gpu_pkg::GPU_FBUF_DATA_WIDTH,
    parameter int FRAME_PIXELS    = gpu_pkg::FRAME_PIXELS,
    parameter int MAX_BURST       = 16,
    parameter int IDLE_TIMEOUT    = 8
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [NUM_REQ-1:0]                   req_valid,
    input  logic [NUM_REQ-1:0]                   req_last,
    input  logic [NUM_REQ*FBUF_ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ*FBUF_DATA_WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]                   req_ready,
    input  logic                                 fbuf_rst_busy,
    output logic                                 fbuf_en_wr,
    output logic                                 fbuf_wrea,
    output logic [FBUF_ADDR_WIDTH-1:0]           fbuf_addr,
    output logic [FBUF_DATA_WIDTH-1:0]           fbuf_data,
    output logic                                 grant_valid,
    output logic [1:0]                           grant_id,
    output logic [15:0]                          err_count
);

    localparam int IDW = GRANT_ID_WIDTH;
    localparam int BCW = $clog2(MAX_BURST + 1);
    localparam int ICW = $clog2(IDLE_TIMEOUT + 1);

    localparam logic [BCW-1:0] c_max_burst    = BCW'(MAX_BURST);
    localparam logic [ICW-1:0] c_idle_timeout = ICW'(IDLE_TIMEOUT);
    localparam logic [IDW-1:0] c_last_id      = IDW'(NUM_REQ - 1);
    localparam logic [31:0]    c_frame_pixels = 32'(FRAME_PIXELS);

    arb_state_t                 r_state;
    logic                       r_was_locked;
    logic [IDW-1:0]             r_rr_ptr;
    logic [IDW-1:0]             r_grant_id;
    logic                       r_grant_valid;
    logic [BCW-1:0]             r_beat_cnt;
    logic [ICW-1:0]             r_idle_cnt;
    logic [15:0]                r_err_count;
    logic                       r_wr_en;
    logic [FBUF_ADDR_WIDTH-1:0] r_wr_addr;
    logic [FBUF_DATA_WIDTH-1:0] r_wr_data;

    logic [IDW-1:0]             w_sel_idx;
    logic                       w_sel_found;
    logic                       w_cur_valid;
    logic                       w_cur_last;
    logic [FBUF_ADDR_WIDTH-1:0] w_cur_addr;
    logic [FBUF_DATA_WIDTH-1:0] w_cur_data;
    logic                       w_accept;
    logic                       w_in_range;
    logic                       w_burst_done;
    logic                       w_timeout;
    logic [IDW-1:0]             w_next_ptr;

    gpu_rr_select #(
        .NUM_REQ   (NUM_REQ),
        .IDX_WIDTH (IDW)
    ) u_rr_select (
        .valid (req_valid),
        .ptr   (r_rr_ptr),
        .idx   (w_sel_idx),
        .found (w_sel_found)
    );

    // Mux out the locked requester's beat and derive the release conditions.
    always_comb begin
        w_cur_valid  = req_valid[r_grant_id];
        w_cur_last   = req_last[r_grant_id];
        w_cur_addr   = req_addr[r_grant_id * FBUF_ADDR_WIDTH +: FBUF_ADDR_WIDTH];
        w_cur_data   = req_data[r_grant_id * FBUF_DATA_WIDTH +: FBUF_DATA_WIDTH];
        w_accept     = (r_state == ARB_LOCKED) && !fbuf_rst_busy && w_cur_valid;
        w_in_range   = 32'(w_cur_addr) < c_frame_pixels;
        w_burst_done = w_cur_last || ((r_beat_cnt + BCW'(1)) == c_max_burst);
        w_timeout    = (r_idle_cnt + ICW'(1)) == c_idle_timeout;
        w_next_ptr   = (r_grant_id == c_last_id) ? '0 : r_grant_id + IDW'(1);
    end

    // Only the lock holder sees ready, and only while the clear is not running.
    // Gating with rst_n keeps ready low throughout a synchronous reset.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign req_ready[gi] = rst_n && (r_state == ARB_LOCKED) && !fbuf_rst_busy
                                   && (r_grant_id == IDW'(gi));
        end
    endgenerate

    // Arbitration FSM: grant, burst/idle counting, release and clear blocking.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ARB_IDLE;
            r_was_locked  <= 1'b0;
            r_rr_ptr      <= '0;
            r_grant_id    <= '0;
            r_grant_valid <= 1'b0;
            r_beat_cnt    <= '0;
            r_idle_cnt    <= '0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (fbuf_rst_busy) begin
                        r_state      <= ARB_BLOCKED;
                        r_was_locked <= 1'b0;
                    end else if (w_sel_found) begin
                        r_state       <= ARB_LOCKED;
                        r_grant_id    <= w_sel_idx;
                        r_grant_valid <= 1'b1;
                        r_beat_cnt    <= '0;
                        r_idle_cnt    <= '0;
                    end
                end
                ARB_LOCKED: begin
                    if (fbuf_rst_busy) begin
                        r_state      <= ARB_BLOCKED;
                        r_was_locked <= 1'b1;
                    end else if (w_accept) begin
                        r_idle_cnt <= '0;
                        if (w_burst_done) begin
                            // Last beat and MAX_BURST together still release once.
                            r_state       <= ARB_IDLE;
                            r_grant_valid <= 1'b0;
                            r_rr_ptr      <= w_next_ptr;
                            r_beat_cnt    <= '0;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + BCW'(1);
                        end
                    end else begin
                        if (w_timeout) begin
                            r_state       <= ARB_IDLE;
                            r_grant_valid <= 1'b0;
                            r_rr_ptr      <= w_next_ptr;
                            r_beat_cnt    <= '0;
                            r_idle_cnt    <= '0;
                        end else begin
                            r_idle_cnt <= r_idle_cnt + ICW'(1);
                        end
                    end
                end
                ARB_BLOCKED: begin
                    if (!fbuf_rst_busy) begin
                        r_state <= r_was_locked ? ARB_LOCKED : ARB_IDLE;
                    end
                end
                default: begin
                    r_state <= ARB_IDLE;
                end
            endcase
        end
    end

    // Write stage: register accepted in-frame beats, count dropped ones.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_err_count <= '0;
        end else begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            if (w_accept) begin
                if (w_in_range) begin
                    r_wr_en   <= 1'b1;
                    r_wr_addr <= w_cur_addr;
                    r_wr_data <= w_cur_data;
                end else if (r_err_count != 16'hFFFF) begin
                    r_err_count <= r_err_count + 16'd1;
                end
            end
        end
    end

    // A beat still sitting in the write stage is suppressed while reset is low.
    assign fbuf_en_wr  = r_wr_en & rst_n;
    assign fbuf_wrea   = r_wr_en & rst_n;
    assign fbuf_addr   = rst_n ? r_wr_addr : '0;
    assign fbuf_data   = rst_n ? r_wr_data : '0;
    assign grant_valid = r_grant_valid;
    assign grant_id    = r_grant_id;
    assign err_count   = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_gpu_fbuf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_gpu_fbuf_write_arbiter
// Description : Self-checking bench for gpu_fbuf_write_arbiter. Requesters
//               are fed from per-requester beat queues; a cycle-level
//               reference model predicts ready/grant/error state and pushes
//               expected BRAM writes into a scoreboard drained by a monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gpu_fbuf_write_arbiter;

    localparam int N  = 3;
    localparam int AW = 19;
    localparam int DW = 8;
    localparam int FP = 307200;
    localparam int MB = 16;
    localparam int IT = 8;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    typedef struct packed {
        logic [31:0]   due;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N-1:0]      req_valid = '0;
    logic [N-1:0]      req_last = '0;
    logic [N*AW-1:0]   req_addr = '0;
    logic [N*DW-1:0]   req_data = '0;
    logic [N-1:0]      req_ready;
    logic              fbuf_rst_busy = 1'b0;
    logic              fbuf_en_wr;
    logic              fbuf_wrea;
    logic [AW-1:0]     fbuf_addr;
    logic [DW-1:0]     fbuf_data;
    logic              grant_valid;
    logic [1:0]        grant_id;
    logic [15:0]       err_count;

    gpu_fbuf_write_arbiter #(
        .NUM_REQ         (N),
        .FBUF_ADDR_WIDTH (AW),
        .FBUF_DATA_WIDTH (DW),
        .FRAME_PIXELS    (FP),
        .MAX_BURST       (MB),
        .IDLE_TIMEOUT    (IT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_last      (req_last),
        .req_addr      (req_addr),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .fbuf_rst_busy (fbuf_rst_busy),
        .fbuf_en_wr    (fbuf_en_wr),
        .fbuf_wrea     (fbuf_wrea),
        .fbuf_addr     (fbuf_addr),
        .fbuf_data     (fbuf_data),
        .grant_valid   (grant_valid),
        .grant_id      (grant_id),
        .err_count     (err_count)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    int unsigned cyc = 0;

    beat_t       bq [N][$];
    wr_t         wq [$];
    logic [N-1:0] gap_en = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input bit ok, input string name,
                         input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Present the head of each requester's beat queue, with optional gaps.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < N; i++) begin
            if (bq[i].size() > 0 && !(gap_en[i] && $urandom_range(3) == 0)) begin
                req_valid[i]           = 1'b1;
                req_last[i]            = bq[i][0].last;
                req_addr[i*AW +: AW]   = bq[i][0].addr;
                req_data[i*DW +: DW]   = bq[i][0].data;
            end else begin
                req_valid[i]           = 1'b0;
                req_last[i]            = 1'b0;
                req_addr[i*AW +: AW]   = '0;
                req_data[i*DW +: DW]   = '0;
            end
        end
    end

    // Retire beats the DUT accepted this cycle.
    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (rst_n && req_valid[i] && req_ready[i] && bq[i].size() > 0) begin
                void'(bq[i].pop_front());
            end
        end
    end

    // Reference model: owner (-1 = nobody), blocked flag, burst/silence counts.
    int          m_holder = -1;
    int          m_beats = 0;
    int          m_silent = 0;
    int          m_ptr = 0;
    bit          m_blk = 1'b0;
    bit          m_prev_rst = 1'b0;
    bit          m_fresh = 1'b1;
    logic [15:0] m_err = '0;

    always @(negedge clk) begin : model
        logic [N-1:0]  exp_ready;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        bit            release_now;
        int            c;
        if (!rst_n) begin
            check(req_ready == '0, "ready_in_reset", 32'(req_ready), 0);
            if (m_prev_rst) begin
                check(grant_valid == 1'b0, "reset_grant_valid", 32'(grant_valid), 0);
                check(grant_id == 2'd0, "reset_grant_id", 32'(grant_id), 0);
                check(err_count == 16'd0, "reset_err_count", 32'(err_count), 0);
            end
            m_holder = -1; m_beats = 0; m_silent = 0; m_ptr = 0;
            m_blk = 1'b0; m_err = '0; m_fresh = 1'b1; m_prev_rst = 1'b1;
        end else begin
            m_prev_rst = 1'b0;
            exp_ready = '0;
            if (!m_blk && m_holder >= 0 && !fbuf_rst_busy) exp_ready[m_holder] = 1'b1;
            check(req_ready == exp_ready, "req_ready", 32'(req_ready), 32'(exp_ready));
            check(grant_valid == (m_holder >= 0), "grant_valid", 32'(grant_valid),
                  32'(m_holder >= 0));
            if (m_holder >= 0 || m_fresh)
                check(grant_id == 2'((m_holder >= 0) ? m_holder : 0), "grant_id",
                      32'(grant_id), 32'((m_holder >= 0) ? m_holder : 0));
            check(err_count == m_err, "err_count", 32'(err_count), 32'(m_err));

            release_now = 1'b0;
            if (m_blk) begin
                if (!fbuf_rst_busy) m_blk = 1'b0;
            end else if (fbuf_rst_busy) begin
                m_blk = 1'b1;
            end else if (m_holder < 0) begin
                for (int k = 0; k < N; k++) begin
                    c = (m_ptr + k) % N;
                    if (m_holder < 0 && req_valid[c]) m_holder = c;
                end
                if (m_holder >= 0) begin
                    m_beats = 0; m_silent = 0; m_fresh = 1'b0;
                end
            end else if (req_valid[m_holder]) begin
                a = req_addr[m_holder*AW +: AW];
                d = req_data[m_holder*DW +: DW];
                m_beats++;
                m_silent = 0;
                if (int'(a) < FP) wq.push_back('{cyc + 1, a, d});
                else if (m_err != 16'hFFFF) m_err = m_err + 16'd1;
                if (req_last[m_holder] || m_beats == MB) release_now = 1'b1;
            end else begin
                m_silent++;
                if (m_silent == IT) release_now = 1'b1;
            end
            if (release_now) begin
                m_ptr = (m_holder + 1) % N;
                m_holder = -1;
            end
        end
    end

    // Monitor: every BRAM write must match the oldest expected write, on time.
    always @(negedge clk) begin : monitor
        wr_t w;
        if (!rst_n) begin
            while (wq.size() > 0 && wq[0].due <= cyc) void'(wq.pop_front());
            check(!fbuf_en_wr && !fbuf_wrea, "write_in_reset", 32'(fbuf_en_wr), 0);
        end else if (fbuf_en_wr || fbuf_wrea) begin
            if (wq.size() == 0) begin
                check(1'b0, "unexpected_write", 32'(fbuf_addr), 0);
            end else begin
                w = wq.pop_front();
                check(w.due == cyc, "write_cycle", cyc, w.due);
                check(fbuf_en_wr && fbuf_wrea, "write_enables",
                      32'({fbuf_en_wr, fbuf_wrea}), 32'h3);
                check(fbuf_addr == w.addr, "fbuf_addr", 32'(fbuf_addr), 32'(w.addr));
                check(fbuf_data == w.data, "fbuf_data", 32'(fbuf_data), 32'(w.data));
            end
        end else begin
            check(fbuf_addr == '0 && fbuf_data == '0, "idle_bus_zero",
                  32'({fbuf_addr, fbuf_data}), 0);
            if (wq.size() > 0 && wq[0].due <= cyc) begin
                check(1'b0, "missing_write", 0, 32'(wq[0].addr));
                void'(wq.pop_front());
            end
        end
    end

    task automatic push_burst(input int id, input int len, input int base,
                              input int dbase, input bit with_last);
        for (int k = 0; k < len; k++) begin
            bq[id].push_back('{AW'(base + k), DW'(dbase + k), with_last && (k == len - 1)});
        end
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < N; i++) if (bq[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic wait_drain(input int max_cycles);
        int t;
        t = 0;
        while (!all_empty() && t < max_cycles) begin
            @(posedge clk);
            t++;
        end
        check(all_empty(), "drain_timeout", 32'(t), 32'(max_cycles));
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin : main
        int len, id, base;
        rst_n = 1'b0;
        idle(3);
        rst_n = 1'b1;
        idle(2);

        // Single burst from requester 1, then a contest that exposes rr_ptr.
        push_burst(1, 4, 0, 8'hA0, 1'b1);
        wait_drain(200);
        idle(IT + 4);
        push_burst(0, 1, 50, 8'h50, 1'b1);
        push_burst(2, 1, 60, 8'h60, 1'b1);
        wait_drain(200);
        idle(4);

        // All three requesters busy with single-beat bursts.
        for (int r = 0; r < 3; r++)
            for (int i = 0; i < N; i++) push_burst(i, 1, 100 * i + r, 16 * i + r, 1'b1);
        wait_drain(200);
        idle(4);

        // Requester 0 streams 20 beats without last; requester 1 waits.
        push_burst(0, 20, 1000, 8'h10, 1'b0);
        push_burst(1, 1, 2000, 8'hEE, 1'b1);
        wait_drain(400);
        idle(IT + 4);

        // Framebuffer clear for 5 cycles in the middle of a burst.
        push_burst(2, 10, 3000, 8'h30, 1'b1);
        idle(4);
        fbuf_rst_busy = 1'b1;
        idle(5);
        fbuf_rst_busy = 1'b0;
        wait_drain(200);
        idle(4);

        // Out-of-frame beat at the first invalid address, then silence.
        bq[0].push_back('{AW'(FP - 1), 8'h11, 1'b0});
        bq[0].push_back('{AW'(FP), 8'h22, 1'b0});
        wait_drain(200);
        idle(IT + 6);

        // Reset in the middle of a burst.
        push_burst(1, 10, 4000, 8'h40, 1'b1);
        idle(4);
        @(posedge clk); #2;
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) bq[i].delete();
        idle(3);
        rst_n = 1'b1;
        idle(3);

        // Randomized traffic with gaps, stray out-of-frame beats and clears.
        gap_en = '1;
        repeat (40) begin
            id   = $urandom_range(N - 1);
            len  = $urandom_range(1, 20);
            base = ($urandom_range(7) == 0) ? FP + $urandom_range(200)
                                            : $urandom_range(FP - 64);
            push_burst(id, len, base, $urandom_range(255), $urandom_range(3) != 0);
            idle($urandom_range(1, 25));
            if ($urandom_range(4) == 0) begin
                fbuf_rst_busy = 1'b1;
                idle($urandom_range(1, 6));
                fbuf_rst_busy = 1'b0;
            end
        end
        wait_drain(3000);
        gap_en = '0;
        idle(IT + 6);

        check(wq.size() == 0, "writes_outstanding", 32'(wq.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
